// File: rtl/gp_axis_pkg.sv
// Shared definitions for the host-side AXI-Stream frame driver.
package gp_axis_pkg;

    // Default stream and buffer word width.
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Exchange sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_RECV  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/gp_axis_host.sv
// Host-side AXI-Stream driver: streams TX_NUM words out of a synchronous-read
// source buffer, then collects an RX_NUM-word result frame into a result buffer
// and pulses done, flagging err on a result frame of the wrong length.
module gp_axis_host
    import gp_axis_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int TX_NUM       = 8,
    parameter int RX_NUM       = 4,
    parameter int TX_ADR_WIDTH = 3,
    parameter int RX_ADR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [TX_ADR_WIDTH-1:0] rd_adr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [RX_ADR_WIDTH-1:0] wr_adr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_en
);

    // Final counter values of each frame, at full counter width.
    localparam logic [TX_ADR_WIDTH-1:0] TX_LAST = TX_ADR_WIDTH'(TX_NUM - 1);
    localparam logic [RX_ADR_WIDTH-1:0] RX_LAST = RX_ADR_WIDTH'(RX_NUM - 1);

    state_t                  state_q, state_d;
    logic [TX_ADR_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [RX_ADR_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;

    logic                    rx_hs;
    logic                    rx_at_last;

    assign rx_hs      = (state_q == ST_RECV) && s_valid;
    assign rx_at_last = (rx_cnt_q == RX_LAST);

    // Next-state, counter and output-register computation.
    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        err_d    = err_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    err_d    = 1'b0;
                end
            end
            ST_FETCH: begin
                // rd_data already reflects tx_cnt (address was issued a cycle early).
                state_d  = ST_SEND;
                m_data_d = rd_data;
                m_last_d = (tx_cnt_q == TX_LAST);
            end
            ST_SEND: begin
                if (m_ready) begin
                    m_last_d = 1'b0;
                    if (tx_cnt_q == TX_LAST) begin
                        state_d = ST_RECV;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_RECV: begin
                if (rx_hs) begin
                    if (s_last || rx_at_last) begin
                        // Frame ends here; a length mismatch is either an early
                        // last or a full frame without last.
                        state_d = ST_DONE;
                        err_d   = err_q | (s_last != rx_at_last);
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            err_q    <= 1'b0;
            m_data_q <= '0;
            m_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            err_q    <= err_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
        end
    end

    // The source buffer has one cycle of read latency, so the address follows
    // the next counter value: the word is ready by the time FETCH captures it,
    // and rd_adr equals tx_cnt throughout FETCH.
    assign rd_adr  = tx_cnt_d;

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign m_valid = (state_q == ST_SEND);
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign s_ready = (state_q == ST_RECV);
    assign wr_en   = rx_hs;
    assign wr_adr  = rx_hs ? rx_cnt_q : '0;
    assign wr_data = rx_hs ? s_data : '0;

endmodule

// File: tb/tb_gp_axis_host.sv
// Scoreboard bench for gp_axis_host: stimulus pushes expected stream words,
// buffer writes and err flags; a negedge monitor pops and compares them.
module tb_gp_axis_host;
    import gp_axis_pkg::*;

    localparam int DW = 32;
    localparam int TXN = 8;
    localparam int RXN = 4;

    logic          clk, rst, start;
    logic          busy, done, err;
    logic [2:0]    rd_adr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, m_ready;
    logic [DW-1:0] s_data;
    logic          s_valid, s_last, s_ready;
    logic [1:0]    wr_adr;
    logic [DW-1:0] wr_data;
    logic          wr_en;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] src_mem [TXN];
    logic [32:0]   exp_tx[$];
    logic [33:0]   exp_wr[$];
    logic          exp_err[$];

    gp_axis_host #(
        .DATA_WIDTH(DW), .TX_NUM(TXN), .RX_NUM(RXN),
        .TX_ADR_WIDTH(3), .RX_ADR_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .rd_adr(rd_adr), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .wr_adr(wr_adr), .wr_data(wr_data), .wr_en(wr_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read source buffer model.
    always @(posedge clk) rd_data <= src_mem[rd_adr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every stream beat, buffer write and done against the queues.
    initial begin
        logic          stall_prev;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [32:0]   et;
        logic [33:0]   ew;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (m_valid) begin
                    if (stall_prev) begin
                        chk("m_data_hold", 64'(m_data), 64'(prev_data));
                        chk("m_last_hold", 64'(m_last), 64'(prev_last));
                    end
                    if (m_ready) begin
                        if (exp_tx.size() == 0) begin
                            chk("tx_unexpected", 64'(m_data), 64'hDEAD);
                        end else begin
                            et = exp_tx.pop_front();
                            chk("tx_data", 64'(m_data), 64'(et[31:0]));
                            chk("tx_last", 64'(m_last), 64'(et[32]));
                            $display("tx word %0d last=%0b", m_data, m_last);
                        end
                    end
                    stall_prev = !m_ready;
                    prev_data  = m_data;
                    prev_last  = m_last;
                end else begin
                    stall_prev = 1'b0;
                end
                if (wr_en) begin
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", 64'(wr_data), 64'hDEAD);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("wr_adr", 64'(wr_adr), 64'(ew[33:32]));
                        chk("wr_data", 64'(wr_data), 64'(ew[31:0]));
                        $display("rx write adr=%0d data=%0d", wr_adr, wr_data);
                    end
                end
                if (done) begin
                    if (exp_err.size() == 0) begin
                        chk("done_unexpected", 64'(done), 64'h0);
                    end else begin
                        chk("err", 64'(err), 64'(exp_err.pop_front()));
                        $display("done err=%0b", err);
                    end
                end
            end
        end
    end

    // One frame exchange. Result words offered are idx+2; last_idx<0 means no s_last.
    // bp stalls m_ready two cycles in three; extra pulses start during SEND and in DONE.
    task automatic exchange(input int n_offer, input int last_idx, input bit bp, input bit extra);
        int idx = 0;
        int k = 0;
        int n_acc;
        bit seen_v = 0;
        bit pulsed = 0;
        bit fin = 0;
        for (int i = 0; i < TXN; i++) exp_tx.push_back({(i == TXN - 1), 32'(i + 1)});
        if (last_idx >= 0 && last_idx < RXN) n_acc = last_idx + 1;
        else n_acc = (n_offer < RXN) ? n_offer : RXN;
        for (int i = 0; i < n_acc; i++) exp_wr.push_back({2'(i), 32'(i + 2)});
        exp_err.push_back(last_idx != RXN - 1);
        while (!fin && k < 300) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 0) start = 1'b1;
            if (extra && m_valid && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (extra && done) start = 1'b1;
            m_ready = bp ? (k % 3 == 0) : 1'b1;
            s_valid = (idx < n_offer);
            s_data  = 32'(idx + 2);
            s_last  = (idx == last_idx);
            @(negedge clk);
            if (m_valid && !seen_v) begin
                seen_v = 1'b1;
                chk("start_latency", 64'(k), 64'd2);
            end
            if (s_valid && s_ready) idx++;
            if (done) begin
                chk("s_ready_in_done", 64'(s_ready), 64'd0);
                chk("busy_in_done", 64'(busy), 64'd1);
                fin = 1'b1;
            end
            k++;
        end
        chk("exchange_timeout", 64'(fin), 64'd1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(m_last), 64'd0);
        chk({tag, "_m_data"}, 64'(m_data), 64'd0);
        chk({tag, "_rd_adr"}, 64'(rd_adr), 64'd0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_adr"}, 64'(wr_adr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    // Main sequence.
    initial begin
        bit hit;
        for (int i = 0; i < TXN; i++) src_mem[i] = 32'(i + 1);
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");

        exchange(4, 3, 1'b0, 1'b0);   // basic
        exchange(4, 3, 1'b1, 1'b0);   // backpressure
        exchange(2, 1, 1'b0, 1'b0);   // early last
        exchange(5, -1, 1'b0, 1'b0);  // missing last, 5th word left waiting
        exchange(4, 3, 1'b0, 1'b1);   // start while busy and in done
        exchange(4, 3, 1'b0, 1'b0);   // start on the cycle after done

        // Reset while word 4 (tx_cnt=3) is presented.
        @(posedge clk); #1;
        start = 1'b1; m_ready = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < TXN; i++) exp_tx.push_back({(i == TXN - 1), 32'(i + 1)});
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (m_valid && m_data == 32'd4) begin
                m_ready = 1'b0;
                rst     = 1'b1;
                hit     = 1'b1;
            end
        end
        chk("reach_tx_cnt3", 64'(hit), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("midreset");
        chk("midreset_pending_words", 64'(exp_tx.size()), 64'd5);
        exp_tx.delete();
        exchange(4, 3, 1'b0, 1'b0);   // re-sends from word 1

        repeat (2) @(posedge clk);
        chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("err_queue_empty", 64'(exp_err.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
